// File: rtl/input_stream_sequencer_if.sv
// Stream bus between the test-vector memory, the input sequencer and the first layer.
// INPUT_STREAM_CHECKSUM_EN adds the 16-bit running checksum signal.
interface input_stream_sequencer_if #(
    parameter int IDX_W = 6
);
    logic             start;
    logic [31:0]      test_num;
    logic             abort;
    logic [31:0]      test_sel;
    logic [31:0]      input_sel;
    logic [7:0]       mem_data;
    logic [7:0]       out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             err;
`ifdef INPUT_STREAM_CHECKSUM_EN
    logic [15:0]      checksum;

    modport master (
        input  start, test_num, abort, mem_data, out_ready,
        output test_sel, input_sel, out_data, out_idx, out_valid, out_last,
               busy, done, err, checksum
    );
    modport slave (
        output start, test_num, abort, mem_data, out_ready,
        input  test_sel, input_sel, out_data, out_idx, out_valid, out_last,
               busy, done, err, checksum
    );
`else
    modport master (
        input  start, test_num, abort, mem_data, out_ready,
        output test_sel, input_sel, out_data, out_idx, out_valid, out_last,
               busy, done, err
    );
    modport slave (
        output start, test_num, abort, mem_data, out_ready,
        input  test_sel, input_sel, out_data, out_idx, out_valid, out_last,
               busy, done, err
    );
`endif
endinterface

// File: rtl/input_stream_sequencer.sv
// Reads one test vector from the input memory and streams it byte-by-byte to the first layer.
// Optional INPUT_STREAM_CHECKSUM_EN: 16-bit sum of all transferred bytes.
module input_stream_sequencer #(
    parameter int N_INPUTS = 62,
    parameter int N_TESTS  = 750,
    parameter int IDX_W    = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input_stream_sequencer_if.master  sif
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(N_INPUTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    logic [1:0]       state_q, state_d;
    logic [31:0]      test_sel_q, test_sel_d;
    logic [IDX_W-1:0] input_sel_q, input_sel_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef INPUT_STREAM_CHECKSUM_EN
    logic [15:0]      checksum_q, checksum_d;
`endif

    logic xfer;
    logic load;
    logic num_ok;

    assign xfer   = out_valid_q && sif.out_ready;
    assign load   = (state_q == STREAM) && (!out_valid_q || sif.out_ready) && (rd_idx_q < NUM_IDX);
    assign num_ok = (sif.test_num != 32'd0) && (sif.test_num <= 32'(N_TESTS));

    always_comb begin
        state_d     = state_q;
        test_sel_d  = test_sel_q;
        input_sel_d = input_sel_q;
        rd_idx_d    = rd_idx_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef INPUT_STREAM_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (sif.start) begin
                    if (num_ok) begin
                        test_sel_d  = sif.test_num;
                        rd_idx_d    = '0;
                        input_sel_d = '0;
                        state_d     = STREAM;
`ifdef INPUT_STREAM_CHECKSUM_EN
                        checksum_d  = 16'd0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM, DRAIN: begin
                // abort takes priority over any transfer happening in the same cycle
                if (sif.abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    rd_idx_d    = '0;
                    input_sel_d = '0;
                    state_d     = IDLE;
                end else begin
`ifdef INPUT_STREAM_CHECKSUM_EN
                    if (xfer) checksum_d = checksum_q + {8'd0, out_data_q};
`endif
                    if (load) begin
                        out_data_d  = sif.mem_data;
                        out_idx_d   = rd_idx_q;
                        out_last_d  = (rd_idx_q == LAST_IDX);
                        out_valid_d = 1'b1;
                        rd_idx_d    = rd_idx_q + 1'b1;
                        // input_sel parks on the last real index once the vector is read out
                        if (rd_idx_q == LAST_IDX) state_d = DRAIN;
                        else                      input_sel_d = rd_idx_q + 1'b1;
                    end else if (xfer) begin
                        out_valid_d = 1'b0;
                    end
                    if ((state_q == DRAIN) && xfer && out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            test_sel_q  <= '0;
            input_sel_q <= '0;
            rd_idx_q    <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef INPUT_STREAM_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            test_sel_q  <= test_sel_d;
            input_sel_q <= input_sel_d;
            rd_idx_q    <= rd_idx_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef INPUT_STREAM_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign sif.test_sel  = test_sel_q;
    assign sif.input_sel = {{(32-IDX_W){1'b0}}, input_sel_q};
    assign sif.out_data  = out_data_q;
    assign sif.out_idx   = out_idx_q;
    assign sif.out_valid = out_valid_q;
    assign sif.out_last  = out_last_q;
    assign sif.busy      = (state_q != IDLE);
    assign sif.done      = done_q;
    assign sif.err       = err_q;
`ifdef INPUT_STREAM_CHECKSUM_EN
    assign sif.checksum  = checksum_q;
`endif
endmodule

// File: tb/tb_input_stream_sequencer.sv
// Scoreboard bench for input_stream_sequencer: stimulus queues expected bytes, a negedge monitor checks them.
module tb_input_stream_sequencer;
    localparam int N_INPUTS = 62;
    localparam int N_TESTS  = 750;
    localparam int IDX_W    = 6;

    typedef struct packed {
        logic [7:0]       data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    input_stream_sequencer_if #(.IDX_W(IDX_W)) sif();

    input_stream_sequencer #(
        .N_INPUTS(N_INPUTS), .N_TESTS(N_TESTS), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sif(sif)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] t;
        t = a * 32'd37 + (a >> 8) + 32'd11;
        return t[7:0];
    endfunction

    assign sif.mem_data = (sif.test_sel == 32'd0) ? 8'h00 :
                          mem_byte((sif.test_sel - 32'd1) * 32'd62 + sif.input_sel);

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   xfer_cnt = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    bit   pend_done = 0;
    bit   ready_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ready driver: always 1, or the repeating 1,0,0,1 pattern
    initial begin
        int ph;
        ph = 0;
        sif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            sif.out_ready = ready_mode ? ((ph == 0) || (ph == 3)) : 1'b1;
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_done = 0;
                continue;
            end
            if (sif.done) done_cnt++;
            if (pend_done) begin
                chk("done_pulse", sif.done, 1);
                chk("busy_after_done", sif.busy, 0);
                pend_done = 0;
            end else if (sif.done) begin
                chk("spurious_done", sif.done, 0);
            end
            if (sif.out_valid && !sif.abort) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", sif.out_valid, 0);
                end else begin
                    e = exp_q[0];
                    chk(sif.out_ready ? "xfer_data" : "hold_data", sif.out_data, e.data);
                    chk(sif.out_ready ? "xfer_idx"  : "hold_idx",  sif.out_idx,  e.idx);
                    chk(sif.out_ready ? "xfer_last" : "hold_last", sif.out_last, e.last);
                    if (sif.out_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                        if (e.idx == 0) first_cyc = cyc;
                        if (e.last) begin
                            last_cyc  = cyc;
                            pend_done = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic push_vec(input int t);
        exp_t e;
        for (int i = 0; i < N_INPUTS; i++) begin
            e.data = mem_byte(32'((t - 1) * N_INPUTS + i));
            e.idx  = IDX_W'(i);
            e.last = (i == N_INPUTS - 1);
            exp_q.push_back(e);
        end
        xfer_cnt = 0;
    endtask

    task automatic do_start(input int t);
        sif.start    = 1'b1;
        sif.test_num = 32'(t);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
    endtask

    task automatic wait_xfers(input int n);
        int b;
        b = 0;
        while (xfer_cnt < n && b < 2000) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (xfer_cnt < n) chk("xfer_timeout", xfer_cnt, n);
    endtask

    task automatic wait_done(input int prev);
        int b;
        b = 0;
        while (done_cnt <= prev && b < 2000) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (done_cnt <= prev) chk("done_timeout", done_cnt, prev + 1);
    endtask

    task automatic run_full(input int t, input string tag);
        int d0;
        d0 = done_cnt;
        push_vec(t);
        do_start(t);
        wait_done(d0);
        chk({tag, "_xfers"}, xfer_cnt, N_INPUTS);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_test_sel"}, sif.test_sel, t);
        chk({tag, "_input_sel"}, sif.input_sel, N_INPUTS - 1);
        chk({tag, "_busy"}, sif.busy, 0);
    endtask

    initial begin
        int d0;
        int unsigned sum;
        sif.start    = 1'b0;
        sif.test_num = 32'd0;
        sif.abort    = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", sif.out_valid, 0);
        chk("rst_out_data", sif.out_data, 0);
        chk("rst_out_idx", sif.out_idx, 0);
        chk("rst_out_last", sif.out_last, 0);
        chk("rst_busy", sif.busy, 0);
        chk("rst_done", sif.done, 0);
        chk("rst_err", sif.err, 0);
        chk("rst_test_sel", sif.test_sel, 0);
        chk("rst_input_sel", sif.input_sel, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Test 1, ready high: 62 back-to-back transfers
        run_full(1, "t1");
        chk("t1_consecutive", last_cyc - first_cyc, N_INPUTS - 1);

        // Test 750 under 1,0,0,1 backpressure
        ready_mode = 1;
        run_full(750, "t750");
        ready_mode = 0;
        repeat (4) @(posedge clk);
        #1;

        // Illegal test numbers
        do_start(0);
        chk("err0_pulse", sif.err, 1);
        chk("err0_busy", sif.busy, 0);
        chk("err0_test_sel", sif.test_sel, 750);
        @(posedge clk);
        #1;
        chk("err0_clear", sif.err, 0);
        do_start(751);
        chk("err751_pulse", sif.err, 1);
        chk("err751_busy", sif.busy, 0);
        chk("err751_test_sel", sif.test_sel, 750);
        @(posedge clk);
        #1;
        chk("err751_clear", sif.err, 0);

        // Abort after the 10th transfer, then a fresh vector
        d0 = done_cnt;
        push_vec(5);
        do_start(5);
        wait_xfers(10);
        sif.abort = 1'b1;
        @(posedge clk);
        #1;
        sif.abort = 1'b0;
        exp_q.delete();
        chk("abort_out_valid", sif.out_valid, 0);
        chk("abort_out_last", sif.out_last, 0);
        chk("abort_busy", sif.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        run_full(6, "t6");

        // Ignored restart mid-stream, then asynchronous reset
        push_vec(3);
        do_start(3);
        wait_xfers(20);
        do_start(9);
        chk("restart_test_sel", sif.test_sel, 3);
        chk("restart_no_err", sif.err, 0);
        chk("restart_busy", sif.busy, 1);
        wait_xfers(40);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_out_valid", sif.out_valid, 0);
        chk("arst_out_data", sif.out_data, 0);
        chk("arst_out_idx", sif.out_idx, 0);
        chk("arst_out_last", sif.out_last, 0);
        chk("arst_busy", sif.busy, 0);
        chk("arst_test_sel", sif.test_sel, 0);
        chk("arst_input_sel", sif.input_sel, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_full(3, "t3");

        // Test 2 and its checksum
        sum = 0;
        for (int i = 0; i < N_INPUTS; i++) sum += mem_byte(32'(N_INPUTS + i));
        run_full(2, "t2");
`ifdef INPUT_STREAM_CHECKSUM_EN
        chk("checksum", sif.checksum, sum & 32'hFFFF);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
